// File: rtl/page_alloc_enc.sv
// Page allocator: per-page bitmap, binary tree of free flags, and a
// top-down walk (one level per cycle) that picks and claims a free page.
module page_alloc_enc #(
  parameter  int PAGES = 16,
  localparam int LVLS  = $clog2(PAGES)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  output logic            o_rdy,
  input  logic            i_alloc_req,
  input  logic            i_inv,
  output logic            o_alloc_ack,
  output logic            o_alloc_fail,
  output logic [LVLS-1:0] o_alloc_page,
  input  logic            i_free_req,
  input  logic [LVLS-1:0] i_free_page,
  output logic            o_free_err,
  output logic [LVLS:0]   o_free_cnt,
  output logic            o_full,
  output logic            o_empty
);

  localparam int NODES = 2 * PAGES - 1;
  localparam int NW    = LVLS + 1;
  localparam int LW    = $clog2(LVLS + 1);

  typedef enum logic [1:0] {IDLE, SEARCH, COMMIT} state_t;

  state_t          state;
  logic [PAGES-1:0] bitmap;
  logic [LVLS:0]    free_cnt;
  logic [NW-1:0]    node;
  logic [LW-1:0]    lvl;
  logic [LVLS-1:0]  idx;
  logic             inv;

  logic [NODES-1:0] tree;
  logic [NW-1:0]    left_child;
  logic [NW-1:0]    right_child;
  logic             go_right;
  logic             free_hit;
  logic             full_after;

  // Heap-ordered tree: node n has children 2n+1 and 2n+2; leaves start at PAGES-1.
  always_comb begin
    tree = '0;
    for (int i = 0; i < PAGES; i++) begin
      tree[PAGES-1+i] = ~bitmap[i];
    end
    for (int n = PAGES - 2; n >= 0; n--) begin
      tree[n] = tree[2*n+1] | tree[2*n+2];
    end
  end

  assign left_child  = NW'({node, 1'b1});
  assign right_child = left_child + 1'b1;
  assign go_right    = inv ? tree[right_child] : ~tree[left_child];

  // A free accepted alongside an alloc counts toward the full check.
  assign free_hit   = bitmap[i_free_page];
  assign full_after = (free_cnt == '0) && !(i_free_req && free_hit);

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state        <= IDLE;
      bitmap       <= '0;
      free_cnt     <= NW'(PAGES);
      node         <= '0;
      lvl          <= '0;
      idx          <= '0;
      inv          <= 1'b0;
      o_alloc_ack  <= 1'b0;
      o_alloc_fail <= 1'b0;
      o_alloc_page <= '0;
      o_free_err   <= 1'b0;
    end else begin
      o_alloc_ack <= 1'b0;
      o_free_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_free_req) begin
            if (free_hit) begin
              bitmap[i_free_page] <= 1'b0;
              free_cnt            <= free_cnt + 1'b1;
            end else begin
              o_free_err <= 1'b1;
            end
          end
          if (i_alloc_req) begin
            inv <= i_inv;
            if (full_after) begin
              o_alloc_ack  <= 1'b1;
              o_alloc_fail <= 1'b1;
            end else begin
              state <= SEARCH;
              node  <= '0;
              lvl   <= '0;
              idx   <= '0;
            end
          end
        end
        SEARCH: begin
          node <= go_right ? right_child : left_child;
          idx  <= LVLS'({idx, go_right});
          lvl  <= lvl + 1'b1;
          if (lvl == LW'(LVLS - 1)) begin
            state <= COMMIT;
          end
        end
        COMMIT: begin
          bitmap[idx]  <= 1'b1;
          free_cnt     <= free_cnt - 1'b1;
          o_alloc_ack  <= 1'b1;
          o_alloc_fail <= 1'b0;
          o_alloc_page <= idx;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_rdy      = (state == IDLE);
  assign o_free_cnt = free_cnt;
  assign o_full     = (free_cnt == '0);
  assign o_empty    = (free_cnt == NW'(PAGES));

  popcount_matches_cnt: assert property (@(posedge i_clk) disable iff (!i_rstn)
    $countones(bitmap) == (PAGES - int'(free_cnt)));

endmodule

// File: tb/tb_page_alloc_enc.sv
// Self-checking bench for page_alloc_enc: directed steps from the test plan
// followed by randomized alloc/free traffic checked against a page-array model.
module tb_page_alloc_enc;

  localparam int PAGES = 16;
  localparam int LVLS  = 4;

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic            o_rdy;
  logic            i_alloc_req = 1'b0;
  logic            i_inv = 1'b0;
  logic            o_alloc_ack;
  logic            o_alloc_fail;
  logic [LVLS-1:0] o_alloc_page;
  logic            i_free_req = 1'b0;
  logic [LVLS-1:0] i_free_page = '0;
  logic            o_free_err;
  logic [LVLS:0]   o_free_cnt;
  logic            o_full;
  logic            o_empty;

  page_alloc_enc #(.PAGES(PAGES)) dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .o_rdy        (o_rdy),
    .i_alloc_req  (i_alloc_req),
    .i_inv        (i_inv),
    .o_alloc_ack  (o_alloc_ack),
    .o_alloc_fail (o_alloc_fail),
    .o_alloc_page (o_alloc_page),
    .i_free_req   (i_free_req),
    .i_free_page  (i_free_page),
    .o_free_err   (o_free_err),
    .o_free_cnt   (o_free_cnt),
    .o_full       (o_full),
    .o_empty      (o_empty)
  );

  always #5 i_clk = ~i_clk;

  bit model_map[PAGES];
  int model_cnt;
  int checks = 0;
  int fails  = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Preferring left everywhere lands on the lowest free page, right on the highest.
  function automatic int modelPick(input bit inv);
    if (inv) begin
      for (int i = PAGES - 1; i >= 0; i--) if (!model_map[i]) return i;
    end else begin
      for (int i = 0; i < PAGES; i++) if (!model_map[i]) return i;
    end
    return -1;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < PAGES; i++) model_map[i] = 1'b0;
    model_cnt = PAGES;
  endtask

  task automatic checkCounts(input string tag);
    checkOutput({tag, "_cnt"}, o_free_cnt, model_cnt);
    checkOutput({tag, "_full"}, o_full, model_cnt == 0);
    checkOutput({tag, "_empty"}, o_empty, model_cnt == PAGES);
  endtask

  task automatic applyStimulus(input bit alloc, input bit inv, input bit fre, input int fpage);
    bit free_ok;
    int exp_page;
    int lat;
    @(negedge i_clk);
    checkOutput("rdy_idle", o_rdy, 1);
    i_alloc_req = alloc;
    i_inv       = inv;
    i_free_req  = fre;
    i_free_page = fpage[LVLS-1:0];
    free_ok = fre && model_map[fpage];
    if (free_ok) begin
      model_map[fpage] = 1'b0;
      model_cnt++;
    end
    @(negedge i_clk);
    i_alloc_req = 1'b0;
    i_free_req  = 1'b0;
    if (fre) checkOutput("free_err", o_free_err, !free_ok);
    if (alloc) begin
      exp_page = modelPick(inv);
      lat = 1;
      while (!o_alloc_ack && lat < 20) begin
        checkOutput("rdy_busy", o_rdy, 0);
        // Requests while busy must be ignored.
        i_alloc_req = 1'($urandom_range(0, 1));
        i_inv       = 1'($urandom_range(0, 1));
        i_free_req  = 1'($urandom_range(0, 1));
        i_free_page = LVLS'($urandom_range(0, PAGES - 1));
        @(negedge i_clk);
        if (!o_alloc_ack) checkOutput("busy_free_err", o_free_err, 0);
        lat++;
      end
      i_alloc_req = 1'b0;
      i_free_req  = 1'b0;
      checkOutput("ack_latency", lat, (exp_page < 0) ? 1 : LVLS + 2);
      checkOutput("alloc_ack", o_alloc_ack, 1);
      checkOutput("alloc_fail", o_alloc_fail, exp_page < 0);
      if (exp_page >= 0) begin
        model_map[exp_page] = 1'b1;
        model_cnt--;
        checkOutput("alloc_page", o_alloc_page, exp_page);
      end
    end
    checkCounts("after_op");
    @(negedge i_clk);
    checkOutput("ack_pulse", o_alloc_ack, 0);
    checkOutput("err_pulse", o_free_err, 0);
  endtask

  task automatic doReset();
    @(negedge i_clk);
    i_rstn      = 1'b0;
    i_alloc_req = 1'b0;
    i_free_req  = 1'b0;
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    modelReset();
  endtask

  initial begin
    modelReset();
    // Reset state
    @(negedge i_clk);
    @(negedge i_clk);
    checkOutput("rst_rdy", o_rdy, 1);
    checkOutput("rst_ack", o_alloc_ack, 0);
    checkOutput("rst_fail", o_alloc_fail, 0);
    checkOutput("rst_err", o_free_err, 0);
    checkOutput("rst_page", o_alloc_page, 0);
    checkCounts("rst");
    checkOutput("rst_cnt16", o_free_cnt, 16);
    i_rstn = 1'b1;

    // Single allocs from empty in each direction
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("two_alloc_cnt14", o_free_cnt, 14);

    // Fill completely, then alloc on full fails
    doReset();
    for (int i = 0; i < PAGES; i++) applyStimulus(1, 0, 0, 0);
    checkOutput("filled_full", o_full, 1);
    applyStimulus(1, 0, 0, 0);

    // Free 5, reclaim it from the right, double free errors
    applyStimulus(0, 0, 1, 5);
    checkOutput("free5_cnt1", o_free_cnt, 1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 0, 1, 5);
    applyStimulus(0, 0, 1, 5);
    checkOutput("double_free_cnt1", o_free_cnt, 1);

    // Full map with simultaneous alloc and free of page 9
    applyStimulus(1, 0, 0, 0);
    checkOutput("refull", o_full, 1);
    applyStimulus(1, 0, 1, 9);
    checkOutput("alloc_free_same_page", o_alloc_page, 9);

    // Reset mid-search produces no ack and clears the map
    doReset();
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    @(negedge i_clk);
    i_alloc_req = 1'b1;
    i_inv       = 1'b1;
    @(negedge i_clk);
    i_alloc_req = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b0;
    @(negedge i_clk);
    i_rstn = 1'b1;
    modelReset();
    for (int i = 0; i < 8; i++) begin
      checkOutput("no_ack_after_reset", o_alloc_ack, 0);
      @(negedge i_clk);
    end
    checkCounts("mid_search_reset");
    applyStimulus(1, 0, 0, 0);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 4))
        0, 1: applyStimulus(1, 1'($urandom_range(0, 1)), 0, 0);
        2:    applyStimulus(0, 0, 1, $urandom_range(0, PAGES - 1));
        default: applyStimulus(1, 1'($urandom_range(0, 1)), 1, $urandom_range(0, PAGES - 1));
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
